pp_frame_decoder: RTL and testbench
===================================

Name: pp_frame_decoder

Overview:
- Receive-side unpacker for the post-processing stream.
- Consumes the 16-bit words read out of the acquisition buffer, each formatted {4'hF, ch1 nibble, ch2 nibble, ch3 nibble}.
- Reassembles DATA_WIDTH/4 consecutive words into three full channel samples, validating the 4'hF marker on every word.
- Sits between the buffer read port and downstream sample consumers (loopback checking, host-side model, re-ordering logic).

Parameters:
- DATA_WIDTH, 16: channel sample width; must be a multiple of 4. Words per frame = WPF = DATA_WIDTH/4.
- ERR_CNT_WIDTH, 8: width of the saturating marker-error counter.
- FRM_CNT_WIDTH, 16: width of the wrapping good-frame counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; realigns to word 0 and clears both counters.
- in_data  in  16  packed word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  decoder accepts in_data this cycle.
- out_ch1  out  DATA_WIDTH  reconstructed channel 1 sample.
- out_ch2  out  DATA_WIDTH  reconstructed channel 2 sample.
- out_ch3  out  DATA_WIDTH  reconstructed channel 3 sample.
- out_valid  out  1  output triple valid.
- out_ready  in  1  downstream accepts the triple.
- sync_err  out  1  one-cycle pulse on a marker mismatch.
- err_count  out  ERR_CNT_WIDTH  saturating count of marker errors.
- frame_count  out  FRM_CNT_WIDTH  wrapping count of frames delivered.

Behaviour:
- Reset (rst=1 at posedge clk): phase=0, assembly registers=0, out_ch*=0, out_valid=0, sync_err=0, err_count=0, frame_count=0. in_ready=1 the cycle after reset.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_ch* and out_valid stay stable while out_valid && !out_ready.
- Word k (phase k, 0..WPF-1) carries bits [DATA_WIDTH-1-4k -: 4] of each channel: MS nibble first, ch1 in bits [11:8], ch2 in [7:4], ch3 in [3:0].
- State machine:
  - ASSEMBLE (phase 0..WPF-1): on each accepted word with marker in_data[15:12]==4'hF, shift the nibbles into the assembly registers and increment phase.
  - If phase==WPF-1 on that word: load out_ch* with the completed values on the next edge, set out_valid, increment frame_count, and return phase to 0.
- Latency: out_valid asserts the cycle after the last word of the frame is accepted.
- in_ready = !(out_valid && !out_ready) || phase != WPF-1. Words 0..WPF-2 are always accepted, so sustained throughput is one word per cycle with no bubble at a frame boundary when out_ready=1.
- Marker error (accepted word with in_data[15:12] != 4'hF):
  - Pulse sync_err for 1 cycle.
  - err_count += 1, saturating at all-ones.
  - Discard the partial frame and set phase=0. The next word is treated as word 0.
  - Assembly registers are not cleared; they are overwritten as the new frame assembles.
- start:
  - Sets phase=0 and clears err_count and frame_count.
  - Does not drop a pending out_valid triple.
  - Any word accepted in the same cycle is ignored (start wins).
- Simultaneous output transfer and last-word accept: the new triple replaces the old one; out_valid stays 1.
- rst mid-frame: the partial frame and any pending output are lost; outputs return to their reset values.
- frame_count wraps modulo 2^FRM_CNT_WIDTH. err_count never wraps.

Decomposition:
- Shared package (pp_pkg):
  - MARKER = 4'hF.
  - NIB_W = 4.
  - Word field offsets (marker [15:12], ch1 [11:8], ch2 [7:4], ch3 [3:0]).
  - Function words_per_frame(DATA_WIDTH).
  - The same package is used by the buffer-write packer, so the field layout is defined in exactly one place.
- One natural sub-module: pp_sat_counter (parameterised width; increment, clear, saturate), instantiated for err_count. frame_count uses a plain wrapping counter.

Test Plan:
- Nominal frame, 1 word/cycle, out_ready=1: feed ch1=0xABC1, ch2=0x1234, ch3=0x0F0F as 0xFA10, 0xFB2F, 0xFC30, 0xF14F.
  -> Next cycle out_valid=1, out_ch1=0xABC1, out_ch2=0x1234, out_ch3=0x0F0F; frame_count=1; sync_err never asserts.
- Back-to-back frames with out_ready=0 after the first frame.
  -> in_ready drops only on phase 3. Words 0–2 of frame 2 are accepted. Outputs are held stable. Raising out_ready delivers frame 1, then frame 2 one cycle later; frame_count=2.
- Corrupt marker: send 0xFA10, then 0x7B2F.
  -> sync_err pulses 1 cycle, err_count=1, no out_valid. The next frame 0xFA10, 0xFB2F, 0xFC30, 0xF14F decodes correctly.
- Saturation: inject 300 bad-marker words.
  -> err_count=0xFF. Then pulse start -> err_count=0, frame_count=0.
- start mid-frame: send 0xFA10 and 0xFB2F, pulse start, then a full 4-word frame.
  -> Exactly one output triple, equal to the post-start frame.
- rst asserted with out_valid=1 pending.
  -> Next cycle out_valid=0, out_ch*=0, counters=0, in_ready=1.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared word layout for the post-processing stream (packer and decoder).
package pp_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned NIB_W      = 4;
  localparam logic [3:0]  MARKER     = 4'hF;

  // Field offsets inside a packed stream word
  localparam int unsigned MARKER_LSB = 12;
  localparam int unsigned CH1_LSB    = 8;
  localparam int unsigned CH2_LSB    = 4;
  localparam int unsigned CH3_LSB    = 0;

  // One stream word: marker nibble followed by one nibble per channel
  typedef struct packed {
    logic [NIB_W-1:0] marker;
    logic [NIB_W-1:0] ch1;
    logic [NIB_W-1:0] ch2;
    logic [NIB_W-1:0] ch3;
  } pp_word_t;

  // Number of stream words needed to carry one sample of each channel
  function automatic int unsigned words_per_frame(input int unsigned data_width);
    return data_width / NIB_W;
  endfunction

endpackage

// File: rtl/pp_sat_counter.sv
// Saturating up-counter with synchronous clear.
module pp_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  // Count up on i_inc, hold at all-ones, clear on rst or i_clr
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {WIDTH{1'b1}})) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pp_frame_decoder.sv
// Unpacks marker-tagged 16-bit words into three DATA_WIDTH channel samples.
module pp_frame_decoder
  import pp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ERR_CNT_WIDTH = 8,
  parameter int unsigned FRM_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WORD_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_ch1,
  output logic [DATA_WIDTH-1:0]    out_ch2,
  output logic [DATA_WIDTH-1:0]    out_ch3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sync_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [FRM_CNT_WIDTH-1:0] frame_count
);

  localparam int unsigned WPF  = words_per_frame(DATA_WIDTH);
  localparam int unsigned PH_W = (WPF > 1) ? $clog2(WPF) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(WPF - 1);

  pp_word_t              w_word;
  logic                  w_accept;
  logic                  w_marker_ok;
  logic                  w_good;
  logic                  w_bad;
  logic                  w_last;
  logic [PH_W-1:0]       r_phase;
  logic [PH_W-1:0]       w_phase_nxt;
  logic [DATA_WIDTH-1:0] r_asm1;
  logic [DATA_WIDTH-1:0] r_asm2;
  logic [DATA_WIDTH-1:0] r_asm3;
  logic [DATA_WIDTH-1:0] w_asm1_nxt;
  logic [DATA_WIDTH-1:0] w_asm2_nxt;
  logic [DATA_WIDTH-1:0] w_asm3_nxt;

  assign w_word      = pp_word_t'(in_data);
  assign w_accept    = in_valid && in_ready;
  assign w_marker_ok = (w_word.marker == MARKER);
  // start overrides any word accepted in the same cycle
  assign w_good      = w_accept && w_marker_ok && !start;
  assign w_bad       = w_accept && !w_marker_ok && !start;
  assign w_last      = w_good && (r_phase == PH_LAST);

  // Shift the new nibble into the LS end; MS nibble arrives first
  assign w_asm1_nxt  = DATA_WIDTH'({r_asm1, w_word.ch1});
  assign w_asm2_nxt  = DATA_WIDTH'({r_asm2, w_word.ch2});
  assign w_asm3_nxt  = DATA_WIDTH'({r_asm3, w_word.ch3});

  // Phase (word index) state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // Next phase: realign on start or marker error, wrap after the last word
  always_comb begin
    w_phase_nxt = r_phase;
    if (start || w_bad || w_last) begin
      w_phase_nxt = '0;
    end else if (w_good) begin
      w_phase_nxt = r_phase + PH_W'(1);
    end
  end

  // Hold off only the final word while an unaccepted triple is pending
  always_comb begin
    in_ready = 1'b1;
    if (out_valid && !out_ready && (r_phase == PH_LAST)) begin
      in_ready = 1'b0;
    end
  end

  // Assembly shift registers; left untouched on errors
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm1 <= '0;
      r_asm2 <= '0;
      r_asm3 <= '0;
    end else if (w_good) begin
      r_asm1 <= w_asm1_nxt;
      r_asm2 <= w_asm2_nxt;
      r_asm3 <= w_asm3_nxt;
    end
  end

  // Output triple register with valid/ready hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ch1   <= '0;
      out_ch2   <= '0;
      out_ch3   <= '0;
      out_valid <= 1'b0;
    end else if (w_last) begin
      out_ch1   <= w_asm1_nxt;
      out_ch2   <= w_asm2_nxt;
      out_ch3   <= w_asm3_nxt;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Marker-error pulse and wrapping good-frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err    <= 1'b0;
      frame_count <= '0;
    end else begin
      sync_err <= w_bad;
      if (start) begin
        frame_count <= '0;
      end else if (w_last) begin
        frame_count <= frame_count + FRM_CNT_WIDTH'(1);
      end
    end
  end

  pp_sat_counter #(
    .WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (start),
    .i_inc   (w_bad),
    .o_count (err_count)
  );

endmodule

// File: tb/tb_pp_frame_decoder.sv
// Directed bench for pp_frame_decoder with hand-computed expectations.
module tb_pp_frame_decoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_ch1;
  logic [15:0] out_ch2;
  logic [15:0] out_ch3;
  logic        out_valid;
  logic        out_ready;
  logic        sync_err;
  logic [7:0]  err_count;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_err_pulses = 0;
  int n_triples = 0;

  // Frame A: ch1=ABC1 ch2=1234 ch3=0F0F ; Frame B: ch1=1357 ch2=2468 ch3=9ABC
  logic [15:0] frm_a [4] = '{16'hFA10, 16'hFB2F, 16'hFC30, 16'hF14F};
  logic [15:0] frm_b [4] = '{16'hF129, 16'hF34A, 16'hF56B, 16'hF78C};

  pp_frame_decoder #(
    .DATA_WIDTH    (16),
    .ERR_CNT_WIDTH (8),
    .FRM_CNT_WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_ch1     (out_ch1),
    .out_ch2     (out_ch2),
    .out_ch3     (out_ch3),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sync_err    (sync_err),
    .err_count   (err_count),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of sync_err and delivered triples
  always @(posedge clk) begin
    if (sync_err) n_err_pulses = n_err_pulses + 1;
    if (out_valid && out_ready) n_triples = n_triples + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded wait)
  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    while (!in_ready && n < 50) begin
      tick();
      n = n + 1;
    end
    if (n == 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] f [4]);
    for (int i = 0; i < 4; i++) send(f[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int p0;
    int t0;
    rst = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_ch1", 32'(out_ch1), 32'd0);

    // Nominal frame at one word per cycle
    p0 = n_err_pulses;
    send_frame(frm_a);
    chk("nom_valid", 32'(out_valid), 32'd1);
    chk("nom_ch1", 32'(out_ch1), 32'hABC1);
    chk("nom_ch2", 32'(out_ch2), 32'h1234);
    chk("nom_ch3", 32'(out_ch3), 32'h0F0F);
    chk("nom_frame_count", 32'(frame_count), 32'd1);
    tick();
    chk("nom_valid_drop", 32'(out_valid), 32'd0);
    chk("nom_no_sync_err", 32'(n_err_pulses - p0), 32'd0);

    // Back-to-back frames with downstream stalled
    pulse_start();
    chk("b2b_start_clr", 32'(frame_count), 32'd0);
    out_ready = 1'b0;
    send_frame(frm_a);
    chk("b2b_f1_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      send(frm_b[i]);
      chk("b2b_ready_early", 32'(in_ready), (i == 2) ? 32'd0 : 32'd1);
    end
    tick(); tick();
    chk("b2b_hold_valid", 32'(out_valid), 32'd1);
    chk("b2b_hold_ch1", 32'(out_ch1), 32'hABC1);
    chk("b2b_hold_ch3", 32'(out_ch3), 32'h0F0F);
    chk("b2b_ready_last", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = frm_b[3]; out_ready = 1'b1;
    #1;
    chk("b2b_ready_release", 32'(in_ready), 32'd1);
    chk("b2b_deliver_f1", 32'(out_ch2), 32'h1234);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_f2_valid", 32'(out_valid), 32'd1);
    chk("b2b_f2_ch1", 32'(out_ch1), 32'h1357);
    chk("b2b_f2_ch2", 32'(out_ch2), 32'h2468);
    chk("b2b_f2_ch3", 32'(out_ch3), 32'h9ABC);
    chk("b2b_frame_count", 32'(frame_count), 32'd2);
    tick();
    chk("b2b_f2_done", 32'(out_valid), 32'd0);

    // Corrupt marker mid-frame, then a clean frame
    p0 = n_err_pulses;
    send(16'hFA10);
    send(16'h7B2F);
    chk("bad_sync_err", 32'(sync_err), 32'd1);
    chk("bad_err_count", 32'(err_count), 32'd1);
    chk("bad_no_valid", 32'(out_valid), 32'd0);
    tick();
    chk("bad_sync_err_clr", 32'(sync_err), 32'd0);
    chk("bad_pulse_width", 32'(n_err_pulses - p0), 32'd1);
    send_frame(frm_a);
    chk("bad_recover_valid", 32'(out_valid), 32'd1);
    chk("bad_recover_ch1", 32'(out_ch1), 32'hABC1);
    chk("bad_recover_ch2", 32'(out_ch2), 32'h1234);
    chk("bad_recover_ch3", 32'(out_ch3), 32'h0F0F);
    chk("bad_frame_count", 32'(frame_count), 32'd3);
    tick();

    // Error counter saturation (starts at 1)
    for (int i = 0; i < 253; i++) send(16'h0000);
    chk("sat_fe", 32'(err_count), 32'hFE);
    send(16'h0000);
    chk("sat_ff", 32'(err_count), 32'hFF);
    for (int i = 0; i < 46; i++) send(16'h0000);
    chk("sat_hold", 32'(err_count), 32'hFF);
    chk("sat_frame_keep", 32'(frame_count), 32'd3);
    tick();
    pulse_start();
    chk("start_err_clr", 32'(err_count), 32'd0);
    chk("start_frm_clr", 32'(frame_count), 32'd0);

    // start mid-frame; word presented with start must be ignored
    t0 = n_triples;
    send(16'hFA10);
    send(16'hFB2F);
    start = 1'b1; in_valid = 1'b1; in_data = 16'hF000;
    tick();
    start = 1'b0; in_valid = 1'b0;
    send_frame(frm_b);
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_ch1", 32'(out_ch1), 32'h1357);
    chk("mid_ch2", 32'(out_ch2), 32'h2468);
    chk("mid_ch3", 32'(out_ch3), 32'h9ABC);
    tick(); tick(); tick();
    chk("mid_one_triple", 32'(n_triples - t0), 32'd1);
    chk("mid_frame_count", 32'(frame_count), 32'd1);

    // rst with a pending triple
    send(16'h1111);
    out_ready = 1'b0;
    send_frame(frm_a);
    chk("rst_pend_valid", 32'(out_valid), 32'd1);
    chk("rst_pend_err", 32'(err_count), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_ch1", 32'(out_ch1), 32'd0);
    chk("rst2_ch2", 32'(out_ch2), 32'd0);
    chk("rst2_ch3", 32'(out_ch3), 32'd0);
    chk("rst2_err", 32'(err_count), 32'd0);
    chk("rst2_frame", 32'(frame_count), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
